fmul_issue_ctrl: RTL and testbench
==================================

FMUL_ISSUE_CTRL -- requirements
Module: fmul_issue_ctrl

Interface
REQ-001 SHALL have parameter TAG_W, default 5, meaning destination-register tag width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning result-queue entries, which is also the in-flight credit limit.
REQ-003 SHALL have parameter LAT, default 3, meaning accept-to-out_valid cycles, fixed by the multiplier's two internal register stages plus one queue write.
REQ-004 Port: clk  input  1  sole clock, rising edge.
REQ-005 Port: rst  input  1  reset, synchronous, active-high.
REQ-006 Port: in_valid  input  1  operand pair offered.
REQ-007 Port: in_ready  output  1  operand pair can be accepted.
REQ-008 Port: in_x1, in_x2  input  32 each  IEEE-754 single operands.
REQ-009 Port: in_tag  input  TAG_W  tag carried with the operation.
REQ-010 Port: out_valid  output  1  result available at queue head.
REQ-011 Port: out_ready  input  1  consumer takes the head result.
REQ-012 Port: out_y  output  32  product.
REQ-013 Port: out_tag  output  TAG_W  tag of out_y.
REQ-014 Port: busy  output  1  high while any operation is in flight or queued.

Function
REQ-015 An operation SHALL be accepted on a rising edge with in_valid && in_ready; in_x1/in_x2 drive the fmul instance directly, with no extra register.
REQ-016 A 2-stage valid/tag shift register SHALL track each accepted operation, aligned with the fmul stages: v1/t1 load at accept, v2/t2 load from v1/t1 one edge later.
REQ-017 When v2=1, the fmul output y and t2 SHALL be written into the result queue on the next edge, so an op accepted in cycle 0 shows out_valid in cycle 3 (LAT=3).
REQ-018 The fmul instance cannot stall, so flow control SHALL use an occupancy counter occ (0..DEPTH) = in-flight plus queued entries.
REQ-019 occ SHALL increment on accept, decrement on pop (out_valid && out_ready), and stay unchanged when both happen in the same cycle.
REQ-020 in_ready SHALL equal (occ < DEPTH), decoded from registers only, with no combinational path from out_ready or in_valid.
REQ-021 A pop in the same cycle as occ==DEPTH SHALL NOT raise in_ready that cycle; the freed credit is visible the next cycle.
REQ-022 The result queue SHALL be a FIFO of DEPTH entries with wrapping read and write pointers.
REQ-023 out_valid SHALL be high when the queue is non-empty; out_y/out_tag show the head entry and hold stable while out_valid && !out_ready.
REQ-024 A queue write and a pop in the same cycle SHALL both take effect, including when the queue is empty→1 or full.
REQ-025 A write to a full queue is impossible by construction and SHALL be flagged by a simulation assertion.
REQ-026 Results SHALL leave in acceptance order, with no reordering.
REQ-027 busy SHALL equal (occ != 0).
REQ-028 Sustained in_valid=1 and out_ready=1 SHALL give one accept and one result per cycle, given DEPTH >= LAT+1.

Reset
REQ-029 While rst=1 at an edge: occ=0, v1=v2=0, tags=0, queue pointers=0, so out_valid=0, in_ready=0 during reset, busy=0, out_y=0, out_tag=0.
REQ-030 The fmul instance's active-low reset input SHALL be driven by ~rst.
REQ-031 rst mid-operation SHALL discard all in-flight and queued results; no stale result may appear after reset deasserts.
REQ-032 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-033 TAG_W, DEPTH and LAT defaults, plus a result typedef {y[31:0], tag}, SHALL live in shared package fpu_pkg.
REQ-034 The block SHALL instantiate exactly one sub-module, fmul, as the datapath; the FIFO and shift register are implemented inline.

Verification
REQ-035 Single op: in_x1=0x3F800000, in_x2=0x40000000, tag=5 accepted in cycle 0 -> out_valid in cycle 3, out_y=0x40000000, out_tag=5.
REQ-036 Sign/zero/inf: 0xBFC00000×0x40000000 -> 0xC0400000; 0x00000000×0x40490FDB -> 0x00000000; 0x7F800000×0x3F800000 -> 0x7F800000; tags returned in order.
REQ-037 Backpressure: out_ready=0, in_valid held with 6 ops -> exactly 4 accepted, in_ready=0 after the 4th; with out_ready=1, results pop in order and in_ready returns one cycle after the first pop.
REQ-038 Streaming: 32 back-to-back ops with out_ready=1 -> in_ready never drops, 32 results in order, output rate one per cycle from cycle 3.
REQ-039 Reset mid-flight: rst for 1 cycle with 2 in flight and 2 queued -> after reset out_valid=0, busy=0, in_ready=1, and no stale result ever emerges.
REQ-040 Random out_ready toggling against a scoreboard over 1000 random operands -> all tags and products match the fmul reference model, with no queue-overflow assertion.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions.
// Holds the default geometry of the fmul issue controller (tag width,
// result-queue depth, issue latency), the fmul pipeline depth it is built
// around, and the result-queue entry type {y, tag}.
package fpu_pkg;

    localparam int FPU_TAG_W       = 5;  // destination-register tag width
    localparam int FPU_DEPTH       = 4;  // result-queue entries / credit limit
    localparam int FPU_LAT         = 3;  // accept to out_valid, in cycles
    localparam int FPU_FMUL_STAGES = 2;  // register stages inside fmul

    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic [31:0]          y;
        logic [FPU_TAG_W-1:0] tag;
    } fmul_result_t;

endpackage

// File: rtl/fmul.sv
// fmul: IEEE-754 single-precision multiplier, two register stages, no stall.
//   clk     in   rising-edge clock
//   i_rst_n in   synchronous active-low reset (clears the output register)
//   i_x1    in   32-bit operand
//   i_x2    in   32-bit operand
//   o_y     out  32-bit product, valid two edges after the operands
// Round-to-nearest-even. Denormal inputs are treated as zero and results
// below the normal range flush to a signed zero. Results above the range
// become signed infinity. NaN inputs and inf*0 return the canonical quiet NaN.
module fmul
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_x1,
    input  logic [31:0] i_x2,
    output logic [31:0] o_y
);

    // Normalise a 48-bit significand product, round to nearest even and
    // pack, saturating to infinity or flushing to zero at the range limits.
    function automatic logic [31:0] round_pack(
        input logic               sign,
        input logic signed [10:0] exp_in,
        input logic [47:0]        prod
    );
        logic [23:0]        mant;
        logic               guard;
        logic               sticky;
        logic               inc;
        logic [24:0]        mant_rnd;
        logic signed [10:0] exp_n;
        if (prod[47]) begin
            mant   = prod[47:24];
            guard  = prod[23];
            sticky = |prod[22:0];
            exp_n  = exp_in + 11'sd1;
        end else begin
            mant   = prod[46:23];
            guard  = prod[22];
            sticky = |prod[21:0];
            exp_n  = exp_in;
        end
        inc      = guard & (sticky | mant[0]);
        mant_rnd = {1'b0, mant} + {24'd0, inc};
        if (mant_rnd[24]) begin
            mant  = mant_rnd[24:1];
            exp_n = exp_n + 11'sd1;
        end else begin
            mant  = mant_rnd[23:0];
        end
        if (exp_n <= 11'sd0) begin
            return {sign, 31'd0};
        end else if (exp_n >= 11'sd255) begin
            return {sign, 8'hFF, 23'd0};
        end
        return {sign, exp_n[7:0], mant[22:0]};
    endfunction

    // ---- stage p0: unpack, classify, significand multiply ----
    logic [7:0]         w_ea;
    logic [7:0]         w_eb;
    logic               w_zero_a;
    logic               w_zero_b;
    logic               w_inf_a;
    logic               w_inf_b;
    logic               w_nan_a;
    logic               w_nan_b;
    logic signed [10:0] w_exp_p0;
    logic [47:0]        w_prod_p0;

    assign w_ea     = i_x1[30:23];
    assign w_eb     = i_x2[30:23];
    assign w_zero_a = (w_ea == 8'h00);
    assign w_zero_b = (w_eb == 8'h00);
    assign w_inf_a  = (w_ea == 8'hFF) && (i_x1[22:0] == 23'd0);
    assign w_inf_b  = (w_eb == 8'hFF) && (i_x2[22:0] == 23'd0);
    assign w_nan_a  = (w_ea == 8'hFF) && (i_x1[22:0] != 23'd0);
    assign w_nan_b  = (w_eb == 8'hFF) && (i_x2[22:0] != 23'd0);
    assign w_exp_p0 = $signed({3'b000, w_ea}) + $signed({3'b000, w_eb}) - 11'sd127;
    assign w_prod_p0 = 48'({1'b1, i_x1[22:0]}) * 48'({1'b1, i_x2[22:0]});

    logic               r_sign_p1;
    logic signed [10:0] r_exp_p1;
    logic [47:0]        r_prod_p1;
    logic               r_nan_p1;
    logic               r_inf_p1;
    logic               r_zero_p1;

    always_ff @(posedge clk) begin
        r_sign_p1 <= i_x1[31] ^ i_x2[31];
        r_exp_p1  <= w_exp_p0;
        r_prod_p1 <= w_prod_p0;
        r_nan_p1  <= w_nan_a | w_nan_b | (w_inf_a & w_zero_b) | (w_zero_a & w_inf_b);
        r_inf_p1  <= w_inf_a | w_inf_b;
        r_zero_p1 <= w_zero_a | w_zero_b;
    end

    // ---- stage p1: special-case select, normalise, round, pack ----
    logic [31:0] w_y_p1;

    always_comb begin
        w_y_p1 = round_pack(r_sign_p1, r_exp_p1, r_prod_p1);
        if (r_nan_p1) begin
            w_y_p1 = FP32_QNAN;
        end else if (r_inf_p1) begin
            w_y_p1 = {r_sign_p1, 8'hFF, 23'd0};
        end else if (r_zero_p1) begin
            w_y_p1 = {r_sign_p1, 31'd0};
        end
    end

    logic [31:0] r_y_p2;

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_y_p2 <= '0;
        end else begin
            r_y_p2 <= w_y_p1;
        end
    end

    assign o_y = r_y_p2;

endmodule

// File: rtl/fmul_issue_ctrl.sv
// fmul_issue_ctrl: credit-based issue wrapper around one non-stalling fmul.
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   operand pair offered
//   in_ready   out  operand pair can be accepted (credit available)
//   in_x1/x2   in   IEEE-754 single operands, fed straight into fmul
//   in_tag     in   tag carried alongside the operation
//   out_valid  out  result available at queue head
//   out_ready  in   consumer takes the head result
//   out_y      out  product at queue head (0 when empty)
//   out_tag    out  tag of out_y (0 when empty)
//   busy       out  any operation in flight or queued
// The multiplier cannot stall, so a result slot is reserved at accept time:
// occ counts in-flight plus queued operations and never exceeds DEPTH,
// which guarantees every result finds a free queue entry.
// The queue entry type comes from fpu_pkg, so TAG_W must stay equal to
// FPU_TAG_W.
module fmul_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int TAG_W = FPU_TAG_W,
    parameter int DEPTH = FPU_DEPTH,
    parameter int LAT   = FPU_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_x1,
    input  logic [31:0]      in_x2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    logic [OCC_W-1:0] r_occ;
    logic [OCC_W-1:0] r_q_cnt;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             r_vld_p1;
    logic             r_vld_p2;
    logic [TAG_W-1:0] r_tag_p1;
    logic [TAG_W-1:0] r_tag_p2;
    fmul_result_t     r_mem [DEPTH];

    logic             w_accept;
    logic             w_pop;
    logic             w_wr;
    logic [31:0]      w_y;
    fmul_result_t     w_head;

    // Credit check uses only the occ register; rst forces it low so nothing
    // is offered credit while the block is being cleared.
    assign in_ready  = ~rst & (r_occ < OCC_FULL);
    assign w_accept  = in_valid & in_ready;
    assign out_valid = (r_q_cnt != '0);
    assign w_pop     = out_valid & out_ready;
    assign w_wr      = r_vld_p2;
    assign busy      = (r_occ != '0);

    assign w_head  = r_mem[r_rd_ptr];
    assign out_y   = out_valid ? w_head.y   : '0;
    assign out_tag = out_valid ? w_head.tag : '0;

    // ---- stage p0: operands enter fmul directly on accept ----
    fmul u_fmul (
        .clk     (clk),
        .i_rst_n (~rst),
        .i_x1    (in_x1),
        .i_x2    (in_x2),
        .o_y     (w_y)
    );

    // ---- stages p1/p2: valid/tag shadow of the fmul pipeline ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_tag_p1 <= '0;
            r_tag_p2 <= '0;
        end else begin
            r_vld_p1 <= w_accept;
            r_vld_p2 <= r_vld_p1;
            if (w_accept) begin
                r_tag_p1 <= in_tag;
            end
            r_tag_p2 <= r_tag_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ <= '0;
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // ---- queue write: fmul output with its p2 tag ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_q_cnt  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_wr, w_pop})
                2'b10:   r_q_cnt <= r_q_cnt + OCC_W'(1);
                2'b01:   r_q_cnt <= r_q_cnt - OCC_W'(1);
                default: r_q_cnt <= r_q_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= '{y: w_y, tag: r_tag_p2};
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        w_wr |-> (r_q_cnt != OCC_FULL));
    a_lat_matches: assert property (@(posedge clk) LAT == FPU_FMUL_STAGES + 1);
    a_tag_w_matches: assert property (@(posedge clk) TAG_W == FPU_TAG_W);

endmodule

// File: tb/tb_fmul_issue_ctrl.sv
`timescale 1ns/1ps
module tb_fmul_issue_ctrl;
    import fpu_pkg::*;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_x1;
    logic [31:0]      in_x2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_y;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    always #5 clk = ~clk;

    fmul_issue_ctrl #(.TAG_W(TAG_W), .DEPTH(4), .LAT(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x1     (in_x1),
        .in_x2     (in_x2),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;
    logic [36:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Reference product: widen both operands to double, multiply exactly
    // (48 significant bits fit in 53), then round the double to single.
    function automatic logic [31:0] ref_fmul(input logic [31:0] a, input logic [31:0] b);
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic        s;
        logic [63:0] db;
        real         ra;
        real         rb;
        int          fe;
        logic [23:0] m;
        logic        g;
        logic        st;
        logic [24:0] mr;
        ea = a[30:23];
        eb = b[30:23];
        s  = a[31] ^ b[31];
        if ((ea == 8'hFF && a[22:0] != 0) || (eb == 8'hFF && b[22:0] != 0) ||
            (ea == 8'hFF && eb == 8'h00) || (ea == 8'h00 && eb == 8'hFF))
            return 32'h7FC0_0000;
        if (ea == 8'hFF || eb == 8'hFF) return {s, 8'hFF, 23'd0};
        if (ea == 8'h00 || eb == 8'h00) return {s, 31'd0};
        ra = $bitstoreal({1'b0, 11'(ea) + 11'd896, a[22:0], 29'd0});
        rb = $bitstoreal({1'b0, 11'(eb) + 11'd896, b[22:0], 29'd0});
        db = $realtobits(ra * rb);
        fe = int'(db[62:52]) - 896;
        m  = {1'b1, db[51:29]};
        g  = db[28];
        st = |db[27:0];
        if (g && (st || m[0])) begin
            mr = {1'b0, m} + 25'd1;
            if (mr[24]) begin
                m  = mr[24:1];
                fe = fe + 1;
            end else begin
                m = mr[23:0];
            end
        end
        if (fe <= 0) return {s, 31'd0};
        if (fe >= 255) return {s, 8'hFF, 23'd0};
        return {s, 8'(fe), m[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: return r;
            1: return {r[31], 8'($urandom_range(1, 12)), r[22:0]};
            2: return {r[31], 8'($urandom_range(230, 254)), r[22:0]};
            3: begin
                case ($urandom_range(0, 4))
                    0: return 32'h0000_0000;
                    1: return 32'h8000_0000;
                    2: return 32'h7F80_0000;
                    3: return 32'hFF80_0000;
                    default: return 32'h0000_0001;
                endcase
            end
            default: return {r[31], 8'($urandom_range(100, 154)), r[22:0]};
        endcase
    endfunction

    // Settle, update the scoreboard from this cycle's handshakes, then
    // advance to 1 ns after the next rising edge.
    task automatic tick();
        logic [36:0] e;
        #1;
        if (exp_q.size() == 0) chk("no_stale_result", 64'(out_valid), 64'd0);
        if (out_valid && out_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_tag", 64'(out_tag), 64'(e[36:32]));
            chk("sb_y", 64'(out_y), 64'(e[31:0]));
        end
        if (in_valid && in_ready) exp_q.push_back({in_tag, ref_fmul(in_x1, in_x2)});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        int  sent;
        logic w;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_x1 = '0; in_x2 = '0; in_tag = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset state
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_y", 64'(out_y), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        rst = 1'b0;
        #1;
        chk("in_ready_first_cycle", 64'(in_ready), 64'd1);

        // Single op: 1.0 * 2.0, tag 5, out_valid in cycle 3
        in_valid = 1'b1; in_x1 = 32'h3F80_0000; in_x2 = 32'h4000_0000; in_tag = 5'd5;
        tick();
        in_valid = 1'b0;
        chk("single_c1_out_valid", 64'(out_valid), 64'd0);
        chk("single_c1_busy", 64'(busy), 64'd1);
        tick();
        chk("single_c2_out_valid", 64'(out_valid), 64'd0);
        tick();
        chk("single_c3_out_valid", 64'(out_valid), 64'd1);
        chk("single_c3_out_y", 64'(out_y), 64'h4000_0000);
        chk("single_c3_out_tag", 64'(out_tag), 64'd5);
        tick();
        chk("single_hold_out_valid", 64'(out_valid), 64'd1);
        chk("single_hold_out_y", 64'(out_y), 64'h4000_0000);
        chk("single_hold_out_tag", 64'(out_tag), 64'd5);
        out_ready = 1'b1;
        tick();
        chk("single_popped_out_valid", 64'(out_valid), 64'd0);
        chk("single_popped_busy", 64'(busy), 64'd0);

        // Sign / zero / infinity, back to back, tags 1..3
        in_valid = 1'b1; in_x1 = 32'hBFC0_0000; in_x2 = 32'h4000_0000; in_tag = 5'd1;
        tick();
        in_x1 = 32'h0000_0000; in_x2 = 32'h4049_0FDB; in_tag = 5'd2;
        tick();
        in_x1 = 32'h7F80_0000; in_x2 = 32'h3F80_0000; in_tag = 5'd3;
        tick();
        in_valid = 1'b0;
        chk("neg_y", 64'(out_y), 64'hC040_0000);
        chk("neg_tag", 64'(out_tag), 64'd1);
        tick();
        chk("zero_y", 64'(out_y), 64'h0000_0000);
        chk("zero_tag", 64'(out_tag), 64'd2);
        chk("zero_out_valid", 64'(out_valid), 64'd1);
        tick();
        chk("inf_y", 64'(out_y), 64'h7F80_0000);
        chk("inf_tag", 64'(out_tag), 64'd3);
        tick();
        chk("special_drained", 64'(out_valid), 64'd0);

        // Backpressure: out_ready low, six ops offered, only four credits
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = (k < 6);
            in_x1 = 32'h3F80_0000 | (32'(k) << 20);
            in_x2 = 32'h4040_0000;
            in_tag = 5'(10 + k);
            w = in_valid && in_ready;
            tick();
            if (w) k++;
        end
        chk("bp_accepted", 64'(k), 64'd4);
        chk("bp_in_ready_full", 64'(in_ready), 64'd0);
        chk("bp_head_tag", 64'(out_tag), 64'd10);
        chk("bp_head_y", 64'(out_y), 64'h4040_0000);
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_in_ready_pop_cycle", 64'(in_ready), 64'd0);
        tick();
        chk("bp_in_ready_after_pop", 64'(in_ready), 64'd1);
        chk("bp_tag2", 64'(out_tag), 64'd11);
        tick();
        chk("bp_tag3", 64'(out_tag), 64'd12);
        tick();
        chk("bp_tag4", 64'(out_tag), 64'd13);
        tick();
        chk("bp_empty", 64'(out_valid), 64'd0);
        chk("bp_busy", 64'(busy), 64'd0);

        // Streaming: 32 back-to-back ops, one result per cycle from cycle 3
        for (int c = 0; c < 36; c++) begin
            if (c < 32) begin
                in_valid = 1'b1;
                in_x1 = 32'h3F80_0000 + 32'(c) * 32'h0001_2345;
                in_x2 = 32'hC0A0_0000 + 32'(c) * 32'h0000_0777;
                in_tag = 5'(c);
                chk("stream_in_ready", 64'(in_ready), 64'd1);
            end else begin
                in_valid = 1'b0;
            end
            if (c >= 3 && c < 35) chk("stream_out_valid", 64'(out_valid), 64'd1);
            if (c == 35) chk("stream_end_out_valid", 64'(out_valid), 64'd0);
            tick();
        end
        chk("stream_drained", 64'(exp_q.size()), 64'd0);

        // Reset with two ops queued and two in flight
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_x1 = 32'h4000_0000 + 32'(c);
            in_x2 = 32'h4000_0000;
            in_tag = 5'(20 + c);
            tick();
        end
        in_valid = 1'b0;
        chk("mid_queued", 64'(out_valid), 64'd1);
        chk("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        tick();
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_after_out_valid", 64'(out_valid), 64'd0);
        chk("mid_after_busy", 64'(busy), 64'd0);
        chk("mid_after_in_ready", 64'(in_ready), 64'd1);
        chk("mid_after_out_y", 64'(out_y), 64'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) tick();
        chk("mid_after_busy_late", 64'(busy), 64'd0);

        // Random operands against the scoreboard with random out_ready
        sent = 0;
        for (int c = 0; c < 20000 && sent < 1000; c++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_x1 = rand_op();
            in_x2 = rand_op();
            in_tag = 5'($urandom);
            out_ready = $urandom_range(0, 1) == 1;
            w = in_valid && in_ready;
            tick();
            if (w) sent++;
        end
        chk("rand_sent", 64'(sent), 64'd1000);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
        chk("rand_drained", 64'(exp_q.size()), 64'd0);
        chk("rand_busy", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
